// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed-latency word RAM.
// Optional misalignment checking is built when DMEM_ALIGN_CHECK_EN is defined.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_strobe,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // req_ready is high only in IDLE; resp_valid holds with stable data until resp_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic                    cap_write;
    logic [ADDR_WIDTH-1:0]   cap_idx;
    logic [3:0]              cap_strobe;
    logic [31:0]             cap_wdata;
    logic                    cap_err;

    logic [31:0]             mem [0:DEPTH-1];

    logic                    req_err;
    logic                    accept;
    logic                    enter_resp;
    logic                    acc_write;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [3:0]              acc_strobe;
    logic [31:0]             acc_wdata;
    logic                    acc_err;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
    assign dbg_state        = state;

    always_comb begin
        req_err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        if ($countones(req_strobe) == 2 && req_strobe != 4'b0011 && req_strobe != 4'b1100)
            req_err = 1'b1;
        if (req_strobe == 4'b1111 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // With LATENCY==1 the RAM is accessed straight from the request inputs.
    always_comb begin
        accept     = (state == S_IDLE) && req_valid && req_ready;
        enter_resp = (accept && (LATENCY == 1)) || ((state == S_BUSY) && (cnt == 4'd1));
        acc_write  = cap_write;
        acc_idx    = cap_idx;
        acc_strobe = cap_strobe;
        acc_wdata  = cap_wdata;
        acc_err    = cap_err;
        if (state == S_IDLE) begin
            acc_write  = req_write;
            acc_idx    = req_addr[ADDR_WIDTH+1:2];
            acc_strobe = req_strobe;
            acc_wdata  = req_wdata;
            acc_err    = req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && acc_write && !acc_err && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_strobe[i])
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            cap_write  <= 1'b0;
            cap_idx    <= '0;
            cap_strobe <= 4'h0;
            cap_wdata  <= 32'h0;
            cap_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cap_write  <= req_write;
                        cap_idx    <= req_addr[ADDR_WIDTH+1:2];
                        cap_strobe <= req_strobe;
                        cap_wdata  <= req_wdata;
                        cap_err    <= req_err;
                        req_ready  <= 1'b0;
                        state      <= S_BUSY;
                        cnt        <= LAT_M1;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - 4'd1;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                state      <= S_RESP;
                cnt        <= 4'd0;
                resp_valid <= 1'b1;
                resp_err   <= acc_err;
                resp_rdata <= (acc_write || acc_err) ? 32'h0 : mem[acc_idx];
            end
        end
    end

endmodule
